// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   SPI master. Accepts one DATA_WIDTH word per tx_valid/tx_ready handshake and
//   runs one full-duplex frame on cs/sclk/mosi0/miso0, then returns the received
//   word on a single-cycle rx_valid strobe.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | ready for a request; sclk follows cpol, cs all high
//   SETUP | cs asserted, sclk at idle level for one half-period
//   XFER  | 2*DATA_WIDTH sclk edges, one per half-period
//   HOLD  | sclk idle, cs still asserted for one half-period, then rx_valid
//
// Ports
//   pclk, areset          clock, asynchronous active-low reset
//   cpol, cpha, msb_first SPI mode and bit order (captured at acceptance)
//   baud_div              half-period = baud_div+1 pclk cycles (captured)
//   cs_sel                slave index; out-of-range selects no slave
//   tx_valid/tx_ready     request handshake, tx_data = word to send
//   rx_valid/rx_data      received word strobe / holding register
//   busy                  acceptance through rx_valid cycle inclusive
//   sclk, cs, mosi0       serial outputs (all registered)
//   miso0                 serial input
module spi_master_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int NO_OF_SLAVES   = 1,
  parameter int BAUD_DIV_WIDTH = 8,
  localparam int CS_W          = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1
) (
  input  logic                      pclk,
  input  logic                      areset,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic                      msb_first,
  input  logic [BAUD_DIV_WIDTH-1:0] baud_div,
  input  logic [CS_W-1:0]           cs_sel,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  input  logic [DATA_WIDTH-1:0]     tx_data,
  output logic                      rx_valid,
  output logic [DATA_WIDTH-1:0]     rx_data,
  output logic                      busy,
  output logic                      sclk,
  output logic [NO_OF_SLAVES-1:0]   cs,
  output logic                      mosi0,
  input  logic                      miso0
);

  localparam int EC_W = $clog2(2 * DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                    state;
  logic [BAUD_DIV_WIDTH-1:0] cnt;
  logic [BAUD_DIV_WIDTH-1:0] div_r;
  logic [EC_W-1:0]           edge_cnt;
  logic                      cpha_r;
  logic                      msb_r;
  logic [DATA_WIDTH-1:0]     tx_sh;
  logic [DATA_WIDTH-1:0]     rx_sh;
  logic                      last_edge;

  assign last_edge = (edge_cnt == EC_W'(2 * DATA_WIDTH - 1));

  function automatic logic out_bit(input logic [DATA_WIDTH-1:0] w, input logic msb);
    return msb ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                      input logic msb);
    return msb ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  // Received bits enter from the side opposite to the transmit side so the
  // assembled word ends up in natural (non-reversed) order.
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b, input logic msb);
    return msb ? {w[DATA_WIDTH-2:0], b} : {b, w[DATA_WIDTH-1:1]};
  endfunction

  function automatic logic [NO_OF_SLAVES-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NO_OF_SLAVES-1:0] v;
    v = '1;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (sel == CS_W'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state    <= IDLE;
      cnt      <= '0;
      div_r    <= '0;
      edge_cnt <= '0;
      cpha_r   <= 1'b0;
      msb_r    <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      tx_ready <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      busy     <= 1'b0;
      sclk     <= 1'b0;
      cs       <= '1;
      mosi0    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          sclk     <= cpol;
          cs       <= '1;
          busy     <= 1'b0;
          tx_ready <= 1'b1;
          if (tx_valid) begin
            cpha_r   <= cpha;
            msb_r    <= msb_first;
            div_r    <= baud_div;
            cnt      <= baud_div;
            tx_sh    <= tx_data;
            rx_sh    <= '0;
            cs       <= cs_decode(cs_sel);
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
            // cpha=0 slaves sample on the first edge, so the first bit must
            // already be on the wire when cs asserts.
            if (!cpha) mosi0 <= out_bit(tx_data, msb_first);
          end
        end

        SETUP: begin
          if (cnt == '0) begin
            cnt      <= div_r;
            edge_cnt <= '0;
            state    <= XFER;
          end else begin
            cnt <= cnt - BAUD_DIV_WIDTH'(1);
          end
        end

        XFER: begin
          if (cnt == '0) begin
            cnt      <= div_r;
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + EC_W'(1);
            if (!edge_cnt[0]) begin
              // leading edge
              if (cpha_r) begin
                mosi0 <= out_bit(tx_sh, msb_r);
                tx_sh <= shift_out(tx_sh, msb_r);
              end else begin
                rx_sh <= shift_in(rx_sh, miso0, msb_r);
              end
            end else begin
              // trailing edge
              if (cpha_r) begin
                rx_sh <= shift_in(rx_sh, miso0, msb_r);
              end else if (!last_edge) begin
                mosi0 <= out_bit(shift_out(tx_sh, msb_r), msb_r);
                tx_sh <= shift_out(tx_sh, msb_r);
              end
            end
            if (last_edge) state <= HOLD;
          end else begin
            cnt <= cnt - BAUD_DIV_WIDTH'(1);
          end
        end

        HOLD: begin
          if (cnt == '0) begin
            cs       <= '1;
            rx_valid <= 1'b1;
            rx_data  <= rx_sh;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - BAUD_DIV_WIDTH'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
module tb_spi_master_ctrl;

  logic       pclk = 1'b0;
  logic       areset;
  logic       cpol, cpha, msb_first;
  logic [7:0] baud_div;
  logic [0:0] cs_sel;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       sclk;
  logic [0:0] cs;
  logic       mosi0;
  logic       miso0 = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // slave model / bus monitor state
  logic       s_cpol = 1'b0, s_cpha = 1'b0, s_msb = 1'b1;
  logic [7:0] s_word = 8'h00, s_sh = 8'h00, s_rx = 8'h00, s_done = 8'h00;
  logic       s_first = 1'b0;
  int         s_bits = 0, toggles = 0, t1 = 0, t2 = 0;
  int         cs_falls = 0, rxv_cnt = 0, cs_hi_run = 0, last_gap = 0;
  logic       prev_sclk = 1'b0, prev_cs = 1'b1;

  spi_master_ctrl #(.DATA_WIDTH(8), .NO_OF_SLAVES(1), .BAUD_DIV_WIDTH(8)) dut (
    .pclk(pclk), .areset(areset), .cpol(cpol), .cpha(cpha), .msb_first(msb_first),
    .baud_div(baud_div), .cs_sel(cs_sel), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .sclk(sclk), .cs(cs), .mosi0(mosi0), .miso0(miso0)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  // SPI slave: shifts s_word out on miso0, captures mosi0, per s_cpol/s_cpha/s_msb.
  always @(negedge pclk) begin : mon
    logic lead;
    if (rx_valid) rxv_cnt++;
    if (prev_cs && !cs[0]) begin
      cs_falls++;
      last_gap = cs_hi_run;
      toggles = 0; s_bits = 0; s_rx = 8'h00; s_sh = s_word;
      if (!s_cpha) begin
        miso0 = s_msb ? s_sh[7] : s_sh[0];
        s_sh  = s_msb ? (s_sh << 1) : (s_sh >> 1);
      end
    end else if (!cs[0] && (sclk !== prev_sclk)) begin
      toggles++;
      if (toggles == 1) t1 = cyc;
      if (toggles == 2) t2 = cyc;
      lead = (sclk !== s_cpol);
      if (lead == !s_cpha) begin
        s_rx = s_msb ? {s_rx[6:0], mosi0} : {mosi0, s_rx[7:1]};
        if (s_bits == 0) s_first = mosi0;
        s_bits++;
      end else begin
        miso0 = s_msb ? s_sh[7] : s_sh[0];
        s_sh  = s_msb ? (s_sh << 1) : (s_sh >> 1);
      end
    end
    if (!prev_cs && cs[0]) s_done = s_rx;
    if (cs[0]) cs_hi_run++; else cs_hi_run = 0;
    prev_cs = cs[0];
    prev_sclk = sclk;
  end

  task automatic set_mode(input logic p, input logic h, input logic m, input logic [7:0] d);
    cpol = p; cpha = h; msb_first = m; baud_div = d;
    s_cpol = p; s_cpha = h; s_msb = m;
  endtask

  // Sends one word; lat = pclk edges from acceptance to rx_valid.
  task automatic run_frame(input logic [7:0] d, input bit perturb, output logic [7:0] rx,
                           output int lat, output bit busy_rv, output bit rv_after,
                           output bit busy_after, output bit to);
    int n;
    to = 1'b0; lat = 0; rx = 8'h00; busy_rv = 1'b0; rv_after = 1'b0; busy_after = 1'b0;
    @(negedge pclk);
    tx_data = d; tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 100) begin @(negedge pclk); n++; end
    if (!tx_ready) begin to = 1'b1; tx_valid = 1'b0; return; end
    @(posedge pclk);
    @(negedge pclk);
    tx_valid = 1'b0;
    if (perturb) begin
      tx_data = ~d; cpha = ~cpha; msb_first = ~msb_first; cpol = ~cpol; baud_div = 8'd7;
    end
    while (!rx_valid && lat < 6000) begin @(negedge pclk); lat++; end
    if (!rx_valid) begin to = 1'b1; return; end
    rx = rx_data; busy_rv = busy;
    @(negedge pclk);
    rv_after = rx_valid; busy_after = busy;
  endtask

  task automatic test_reset();
    areset = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; cs_sel = 1'b0;
    set_mode(1'b0, 1'b0, 1'b1, 8'd1);
    repeat (3) @(negedge pclk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b exp 0", sclk); end
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL reset_cs got %b exp 1", cs); end
    checks++; if (mosi0 !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", mosi0); end
    areset = 1'b1;
    repeat (2) @(negedge pclk);
  endtask

  task automatic test_mode0();
    logic [7:0] rx; int lat; bit brv, rva, ba, to;
    set_mode(1'b0, 1'b0, 1'b1, 8'd1);
    s_word = 8'h3C;
    run_frame(8'hA5, 1'b1, rx, lat, brv, rva, ba, to);
    checks++; if (to) begin errors++; $display("FAIL mode0_timeout got timeout exp rx_valid"); end
    checks++; if (lat !== 36) begin errors++; $display("FAIL mode0_latency got %0d exp 36", lat); end
    checks++; if (rx !== 8'h3C) begin errors++; $display("FAIL mode0_rx got %h exp 3c", rx); end
    checks++; if (s_done !== 8'hA5) begin errors++; $display("FAIL mode0_mosi got %h exp a5", s_done); end
    checks++; if (s_bits !== 8) begin errors++; $display("FAIL mode0_bits got %0d exp 8", s_bits); end
    checks++; if (brv !== 1'b1) begin errors++; $display("FAIL mode0_busy_rv got %b exp 1", brv); end
    checks++; if (rva !== 1'b0) begin errors++; $display("FAIL mode0_rv_pulse got %b exp 0", rva); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL mode0_busy_after got %b exp 0", ba); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL mode0_rx_hold got %h exp 3c", rx_data); end
    set_mode(1'b0, 1'b0, 1'b1, 8'd1);
  endtask

  task automatic test_modes();
    logic [7:0] rx; int lat; bit brv, rva, ba, to;
    logic p, h;
    for (int m = 0; m < 4; m++) begin
      p = m[1]; h = m[0];
      set_mode(p, h, 1'b1, 8'd1);
      s_word = 8'h7E;
      repeat (3) @(negedge pclk);
      checks++; if (sclk !== p) begin errors++; $display("FAIL modes_idle_sclk m=%0d got %b exp %b", m, sclk, p); end
      run_frame(8'h81, 1'b0, rx, lat, brv, rva, ba, to);
      checks++; if (to || rx !== 8'h7E) begin errors++; $display("FAIL modes_rx m=%0d got %h exp 7e", m, rx); end
      checks++; if (s_done !== 8'h81) begin errors++; $display("FAIL modes_mosi m=%0d got %h exp 81", m, s_done); end
      checks++; if (toggles !== 16) begin errors++; $display("FAIL modes_edges m=%0d got %0d exp 16", m, toggles); end
      checks++; if (sclk !== p) begin errors++; $display("FAIL modes_end_sclk m=%0d got %b exp %b", m, sclk, p); end
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] rx; int lat; bit brv, rva, ba, to;
    set_mode(1'b0, 1'b0, 1'b0, 8'd1);
    s_word = 8'h80;
    run_frame(8'h01, 1'b0, rx, lat, brv, rva, ba, to);
    checks++; if (to || rx !== 8'h80) begin errors++; $display("FAIL lsb_rx got %h exp 80", rx); end
    checks++; if (s_first !== 1'b1) begin errors++; $display("FAIL lsb_first_bit got %b exp 1", s_first); end
    checks++; if (s_done !== 8'h01) begin errors++; $display("FAIL lsb_mosi got %h exp 01", s_done); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r1, r2; int n, rxv0, falls0; logic rdy_rv;
    set_mode(1'b0, 1'b0, 1'b1, 8'd1);
    s_word = 8'hC3;
    r1 = 8'h00; r2 = 8'h00; rdy_rv = 1'b0;
    rxv0 = rxv_cnt; falls0 = cs_falls;
    @(negedge pclk);
    tx_data = 8'h11; tx_valid = 1'b1;
    n = 0;
    while (tx_ready && n < 100) begin @(negedge pclk); n++; end
    repeat (2) @(negedge pclk);
    tx_data = 8'h22; s_word = 8'h3C;
    n = 0;
    while (!rx_valid && n < 200) begin @(negedge pclk); n++; end
    r1 = rx_data; rdy_rv = tx_ready;
    @(negedge pclk);
    tx_valid = 1'b0;
    n = 0;
    while (!rx_valid && n < 200) begin @(negedge pclk); n++; end
    r2 = rx_data;
    @(negedge pclk);
    checks++; if (r1 !== 8'hC3) begin errors++; $display("FAIL b2b_rx1 got %h exp c3", r1); end
    checks++; if (rdy_rv !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_rv got %b exp 1", rdy_rv); end
    checks++; if (r2 !== 8'h3C) begin errors++; $display("FAIL b2b_rx2 got %h exp 3c", r2); end
    checks++; if (rxv_cnt - rxv0 !== 2) begin errors++; $display("FAIL b2b_strobes got %0d exp 2", rxv_cnt - rxv0); end
    checks++; if (cs_falls - falls0 !== 2) begin errors++; $display("FAIL b2b_cs_falls got %0d exp 2", cs_falls - falls0); end
    checks++; if (last_gap < 1) begin errors++; $display("FAIL b2b_cs_gap got %0d exp >=1", last_gap); end
    checks++; if (s_done !== 8'h22) begin errors++; $display("FAIL b2b_mosi2 got %h exp 22", s_done); end
  endtask

  task automatic test_baud();
    logic [7:0] rx; int lat; bit brv, rva, ba, to;
    set_mode(1'b0, 1'b0, 1'b1, 8'd0);
    s_word = 8'h96;
    run_frame(8'h69, 1'b0, rx, lat, brv, rva, ba, to);
    checks++; if (lat !== 18) begin errors++; $display("FAIL baud0_latency got %0d exp 18", lat); end
    checks++; if (2 * (t2 - t1) !== 2) begin errors++; $display("FAIL baud0_period got %0d exp 2", 2 * (t2 - t1)); end
    checks++; if (to || rx !== 8'h96) begin errors++; $display("FAIL baud0_rx got %h exp 96", rx); end
    set_mode(1'b0, 1'b0, 1'b1, 8'd255);
    run_frame(8'h69, 1'b0, rx, lat, brv, rva, ba, to);
    checks++; if (lat !== 4608) begin errors++; $display("FAIL baud255_latency got %0d exp 4608", lat); end
    checks++; if (2 * (t2 - t1) !== 512) begin errors++; $display("FAIL baud255_period got %0d exp 512", 2 * (t2 - t1)); end
    checks++; if (to || rx !== 8'h96) begin errors++; $display("FAIL baud255_rx got %h exp 96", rx); end
  endtask

  task automatic test_cs_out_of_range();
    logic [7:0] rx; int lat; bit brv, rva, ba, to; int falls0;
    set_mode(1'b0, 1'b0, 1'b1, 8'd1);
    cs_sel = 1'b1;
    falls0 = cs_falls;
    run_frame(8'h33, 1'b0, rx, lat, brv, rva, ba, to);
    checks++; if (to || lat !== 36) begin errors++; $display("FAIL cs_range_latency got %0d exp 36", lat); end
    checks++; if (cs_falls !== falls0) begin errors++; $display("FAIL cs_range_falls got %0d exp %0d", cs_falls, falls0); end
    cs_sel = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rx; int lat; bit brv, rva, ba, to; int n, rxv0;
    set_mode(1'b0, 1'b0, 1'b1, 8'd1);
    s_word = 8'hE7;
    @(negedge pclk);
    tx_data = 8'hF0; tx_valid = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    tx_valid = 1'b0;
    n = 0;
    while (toggles < 5 && n < 200) begin @(negedge pclk); n++; end
    checks++; if (toggles < 5) begin errors++; $display("FAIL abort_reach_edge5 got %0d exp 5", toggles); end
    rxv0 = rxv_cnt;
    areset = 1'b0;
    #1;
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL abort_cs got %b exp 1", cs); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk got %b exp 0", sclk); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL abort_tx_ready got %b exp 1", tx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    repeat (3) @(negedge pclk);
    areset = 1'b1;
    repeat (60) @(negedge pclk);
    checks++; if (rxv_cnt !== rxv0) begin errors++; $display("FAIL abort_no_rx_valid got %0d exp %0d", rxv_cnt, rxv0); end
    s_word = 8'hA4;
    run_frame(8'h5A, 1'b0, rx, lat, brv, rva, ba, to);
    checks++; if (to || rx !== 8'hA4) begin errors++; $display("FAIL abort_next_rx got %h exp a4", rx); end
    checks++; if (s_done !== 8'h5A) begin errors++; $display("FAIL abort_next_mosi got %h exp 5a", s_done); end
    checks++; if (lat !== 36) begin errors++; $display("FAIL abort_next_latency got %0d exp 36", lat); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_lsb_first();
    test_back_to_back();
    test_baud();
    test_cs_out_of_range();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
